// File: rtl/mem_port_arbiter.sv
// Round-robin arbiter sharing one slow-memory port between the I-cache and D-cache.
// The winning command is registered and held until mem_ready. Ready is routed to the owner only.
`timescale 1ns/1ps
module mem_port_arbiter #(
  parameter int unsigned ADDR_W = 28,
  parameter int unsigned DATA_W = 128,
  parameter int unsigned CNT_W  = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              i_read,
  input  logic              i_write,
  input  logic [ADDR_W-1:0] i_addr,
  input  logic [DATA_W-1:0] i_wdata,
  output logic              i_ready,
  input  logic              d_read,
  input  logic              d_write,
  input  logic [ADDR_W-1:0] d_addr,
  input  logic [DATA_W-1:0] d_wdata,
  output logic              d_ready,
  output logic [DATA_W-1:0] rdata,
  output logic              mem_read,
  output logic              mem_write,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic              mem_ready,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic              owner,
  output logic              busy,
  output logic [CNT_W-1:0]  i_grants,
  output logic [CNT_W-1:0]  d_grants
);

  typedef enum logic [1:0] {StIdle, StBusy, StRelease} state_e;

  state_e state_q;
  logic   i_pend;
  logic   d_pend;
  logic   grant_d;

  assign i_pend = i_read | i_write;
  assign d_pend = d_read | d_write;

  // owner doubles as the last-served record: a tie goes to whoever was not served last.
  assign grant_d = d_pend & (~i_pend | ~owner);

  assign busy    = (state_q == StBusy);
  assign i_ready = busy & mem_ready & ~owner;
  assign d_ready = busy & mem_ready & owner;
  assign rdata   = mem_rdata;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= StIdle;
      mem_read  <= 1'b0;
      mem_write <= 1'b0;
      mem_addr  <= '0;
      mem_wdata <= '0;
      owner     <= 1'b0;
      i_grants  <= '0;
      d_grants  <= '0;
    end else begin
      unique case (state_q)
        StIdle: begin
          if (i_pend || d_pend) begin
            state_q <= StBusy;
            owner   <= grant_d;
            if (grant_d) begin
              // Simultaneous read and write is forwarded as a write only.
              mem_write <= d_write;
              mem_read  <= d_read & ~d_write;
              mem_addr  <= d_addr;
              mem_wdata <= d_wdata;
              if (d_grants != '1) d_grants <= d_grants + CNT_W'(1);
            end else begin
              mem_write <= i_write;
              mem_read  <= i_read & ~i_write;
              mem_addr  <= i_addr;
              mem_wdata <= i_wdata;
              if (i_grants != '1) i_grants <= i_grants + CNT_W'(1);
            end
          end
        end
        StBusy: begin
          if (mem_ready) begin
            mem_read  <= 1'b0;
            mem_write <= 1'b0;
            state_q   <= StRelease;
          end
        end
        StRelease: state_q <= StIdle;
        default:   state_q <= StIdle;
      endcase
    end
  end

endmodule
